// File: rtl/sram_srw_access_master_pkg.sv
// Shared types and constants for the SRW SRAM access master and its response FIFO.
// Build option: SRAM_SRW_MASTER_WE_EN (per-byte write enables) is consumed by the
// interface and top; nothing here depends on it.
package sram_srw_pkg;

   localparam int SRW_MAX_RESP_DEPTH = 8;
   localparam int SRW_CNT_W          = 4;
   localparam int SRW_PTR_W          = $clog2(SRW_MAX_RESP_DEPTH);
   localparam int SRW_ADDR_W         = 14;
   localparam int SRW_DATA_W         = 32;

   typedef struct packed {
      logic                      read_not_write;
      logic [SRW_ADDR_W-1:0]     address;
      logic [SRW_DATA_W-1:0]     write_data;
      logic [SRW_DATA_W/8-1:0]   byte_enable;
   } t_sram_srw_req;

   // Circular pointer advance for a FIFO whose depth need not be a power of two.
   function automatic logic [SRW_PTR_W-1:0] srw_ptr_next(input logic [SRW_PTR_W-1:0] i_ptr,
                                                         input int                   i_depth);
      return (int'(i_ptr) == i_depth - 1) ? '0 : i_ptr + SRW_PTR_W'(1);
   endfunction

endpackage

// File: rtl/sram_srw_access_master_if.sv
// Request/response/SRAM-port bundle for sram_srw_access_master.
// Build option: SRAM_SRW_MASTER_WE_EN adds req_byte_enable and widens
// sram_write_enable to one bit per data byte.
interface sram_srw_access_master_if #(
   parameter int address_width = 14,
   parameter int data_width    = 32
);
`ifdef SRAM_SRW_MASTER_WE_EN
   localparam int we_width = data_width / 8;
`else
   localparam int we_width = 1;
`endif

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_read_not_write;
   logic [address_width-1:0] req_address;
   logic [data_width-1:0]    req_write_data;
`ifdef SRAM_SRW_MASTER_WE_EN
   logic [we_width-1:0]      req_byte_enable;
`endif
   logic                     resp_valid;
   logic                     resp_ready;
   logic [data_width-1:0]    resp_data;
   logic                     sram_select;
   logic                     sram_read_not_write;
   logic [address_width-1:0] sram_address;
   logic [data_width-1:0]    sram_write_data;
   logic [we_width-1:0]      sram_write_enable;
   logic [data_width-1:0]    sram_data_out;

   // Access-master side: consumes requests and SRAM read data, drives SRAM ports.
   modport master (
`ifdef SRAM_SRW_MASTER_WE_EN
      input  req_byte_enable,
`endif
      input  req_valid, req_read_not_write, req_address, req_write_data,
      input  resp_ready, sram_data_out,
      output req_ready, resp_valid, resp_data,
      output sram_select, sram_read_not_write, sram_address, sram_write_data,
      output sram_write_enable
   );

   // Client/SRAM side: the mirror image of master.
   modport slave (
`ifdef SRAM_SRW_MASTER_WE_EN
      output req_byte_enable,
`endif
      output req_valid, req_read_not_write, req_address, req_write_data,
      output resp_ready, sram_data_out,
      input  req_ready, resp_valid, resp_data,
      input  sram_select, sram_read_not_write, sram_address, sram_write_data,
      input  sram_write_enable
   );

endinterface

// File: rtl/sram_srw_access_master_resp_fifo.sv
// Read-response FIFO: synchronous, depth resp_depth (2..8), head entry shown on o_data.
// Storage is sized for the maximum depth so the 3-bit pointers index it exactly.
module sram_srw_resp_fifo
   import sram_srw_pkg::*;
#(
   parameter int data_width = 32,
   parameter int resp_depth = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [data_width-1:0] i_data,
   output logic [data_width-1:0] o_data,
   output logic                  o_valid,
   output logic [SRW_CNT_W-1:0]  o_count
);
   localparam logic [SRW_CNT_W-1:0] DEPTH_C = SRW_CNT_W'(resp_depth);

   logic [data_width-1:0] r_mem [SRW_MAX_RESP_DEPTH];
   logic [SRW_PTR_W-1:0]  r_wr_ptr;
   logic [SRW_PTR_W-1:0]  r_rd_ptr;
   logic [SRW_CNT_W-1:0]  r_count;
   logic                  w_pop;
   logic                  w_full;

   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && o_valid;
   assign w_full  = (r_count == DEPTH_C);

   // Storage, pointers and occupancy; everything freezes while the clock enable is low.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < SRW_MAX_RESP_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_en) begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= srw_ptr_next(r_wr_ptr, resp_depth);
         end
         if (w_pop) r_rd_ptr <= srw_ptr_next(r_rd_ptr, resp_depth);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + SRW_CNT_W'(1);
            2'b01:   r_count <= r_count - SRW_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The top's credit rule keeps a push away from a full FIFO; catch it if that breaks.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_en) assert (!(i_push && w_full));
   end

endmodule

// File: rtl/sram_srw_access_master.sv
// Valid/ready front end driving a single-port SRW SRAM; read data returns through a
// small FIFO so responses survive back-pressure.
// Build option: SRAM_SRW_MASTER_WE_EN -> per-byte write enables from req_byte_enable.
module sram_srw_access_master
   import sram_srw_pkg::*;
#(
   parameter int address_width = 14,
   parameter int data_width    = 32,
   parameter int resp_depth    = 3
) (
   input logic                      i_sram_clock,
   input logic                      i_reset_n,
   input logic                      i_sram_clock__enable,
   sram_srw_access_master_if.master bus
);
   localparam logic [SRW_CNT_W-1:0] DEPTH_C = SRW_CNT_W'(resp_depth);

   logic                     r_inflight;
   logic [SRW_CNT_W-1:0]     w_count;
   logic                     w_credit;
   logic                     w_req_ready;
   logic                     w_fire;
   logic                     w_write_fire;
   logic                     w_resp_valid;
   logic                     w_pop;
   logic [address_width-1:0] w_address;
   logic [data_width-1:0]    w_write_data;

   // A credit counts both buffered entries and the read whose data lands this edge,
   // so a response never meets a full FIFO and req_ready never sees resp_ready.
   assign w_credit     = (w_count + SRW_CNT_W'(r_inflight)) < DEPTH_C;
   assign w_req_ready  = i_reset_n && i_sram_clock__enable && w_credit;
   assign w_fire       = bus.req_valid && w_req_ready;
   assign w_write_fire = w_fire && !bus.req_read_not_write;
   assign w_pop        = w_resp_valid && bus.resp_ready;
   assign w_address    = bus.req_address;
   assign w_write_data = bus.req_write_data;

   assign bus.req_ready           = w_req_ready;
   assign bus.resp_valid          = w_resp_valid;
   assign bus.sram_select         = w_fire;
   assign bus.sram_read_not_write = bus.req_read_not_write;
   assign bus.sram_address        = w_address;
   assign bus.sram_write_data     = w_write_data;
`ifdef SRAM_SRW_MASTER_WE_EN
   assign bus.sram_write_enable   = w_write_fire ? bus.req_byte_enable : '0;
`else
   assign bus.sram_write_enable   = w_write_fire;
`endif

   // Remember that a read was issued so its data is captured on the next enabled edge.
   always_ff @(posedge i_sram_clock) begin
      if (!i_reset_n) r_inflight <= 1'b0;
      else if (i_sram_clock__enable) r_inflight <= w_fire && bus.req_read_not_write;
   end

   sram_srw_resp_fifo #(
      .data_width (data_width),
      .resp_depth (resp_depth)
   ) u_resp_fifo (
      .i_clk   (i_sram_clock),
      .i_rst_n (i_reset_n),
      .i_en    (i_sram_clock__enable),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_data  (bus.sram_data_out),
      .o_data  (bus.resp_data),
      .o_valid (w_resp_valid),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_sram_srw_access_master.sv
// Directed bench for sram_srw_access_master with a behavioural SRW SRAM, a golden
// memory image and a response scoreboard. Builds with or without SRAM_SRW_MASTER_WE_EN.
module tb_sram_srw_access_master;
   import sram_srw_pkg::*;

   logic clk;
   logic rst_n;
   logic en;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] sram_mem [16384];
   logic [31:0] gold     [16384];
   logic [31:0] sb [$];
   logic [3:0]  we_vec;

   sram_srw_access_master_if #(.address_width(14), .data_width(32)) bus ();

   sram_srw_access_master #(
      .address_width (14),
      .data_width    (32),
      .resp_depth    (3)
   ) dut (
      .i_sram_clock         (clk),
      .i_reset_n            (rst_n),
      .i_sram_clock__enable (en),
      .bus                  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SRAM_SRW_MASTER_WE_EN
   assign we_vec = bus.sram_write_enable;
`else
   assign we_vec = {4{bus.sram_write_enable}};
`endif

   // SRAM model: shares the clock enable, so data_out holds while disabled.
   always @(posedge clk) begin
      if (en && bus.sram_select) begin
         if (bus.sram_read_not_write) bus.sram_data_out <= sram_mem[bus.sram_address];
         else
            for (int b = 0; b < 4; b++)
               if (we_vec[b]) sram_mem[bus.sram_address][8*b +: 8] <= bus.sram_write_data[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every popped response must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && en && bus.resp_valid && bus.resp_ready) begin
         if (sb.size() == 0) check("resp_extra", 64'(sb.size()), 64'd1);
         else check("resp_data", 64'(bus.resp_data), 64'(sb.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.req_valid = 1'b0;
   endtask

   task automatic do_req(input t_sram_srw_req r, output int waits);
      logic       ok;
      logic [3:0] exp_we;
      ok    = 1'b0;
      waits = 0;
      bus.req_valid          = 1'b1;
      bus.req_read_not_write = r.read_not_write;
      bus.req_address        = r.address;
      bus.req_write_data     = r.write_data;
`ifdef SRAM_SRW_MASTER_WE_EN
      bus.req_byte_enable    = r.byte_enable;
      exp_we = r.read_not_write ? 4'b0000 : r.byte_enable;
`else
      exp_we = r.read_not_write ? 4'b0000 : 4'b0001;
`endif
      while (!ok && waits <= 50) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            check("sram_select", 64'(bus.sram_select), 64'd1);
            check("sram_address", 64'(bus.sram_address), 64'(r.address));
            check("sram_we", 64'(bus.sram_write_enable), 64'(exp_we));
         end else waits++;
         @(posedge clk);
         #1;
      end
      check("req_accept", 64'(ok), 64'd1);
      if (ok) begin
         if (r.read_not_write) sb.push_back(gold[r.address]);
         else begin
`ifdef SRAM_SRW_MASTER_WE_EN
            for (int b = 0; b < 4; b++)
               if (r.byte_enable[b]) gold[r.address][8*b +: 8] = r.write_data[8*b +: 8];
`else
            gold[r.address] = r.write_data;
`endif
         end
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (sb.size() != 0 && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   function automatic t_sram_srw_req mk(input logic rnw, input int addr,
                                        input logic [31:0] data, input logic [3:0] be);
      t_sram_srw_req r;
      r.read_not_write = rnw;
      r.address        = 14'(addr);
      r.write_data     = data;
      r.byte_enable    = be;
      return r;
   endfunction

   initial begin
      int w;
      int wsum;
      int acc;

      for (int i = 0; i < 16384; i++) begin
         sram_mem[i] = 32'hC0DE_0000 | 32'(i);
         gold[i]     = 32'hC0DE_0000 | 32'(i);
      end
      rst_n = 1'b0;
      en    = 1'b1;
      bus.req_valid          = 1'b0;
      bus.req_read_not_write = 1'b0;
      bus.req_address        = '0;
      bus.req_write_data     = '0;
`ifdef SRAM_SRW_MASTER_WE_EN
      bus.req_byte_enable    = '0;
`endif
      bus.resp_ready         = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_data", 64'(bus.resp_data), 64'd0);
      check("rst_select", 64'(bus.sram_select), 64'd0);
      check("rst_we", 64'(bus.sram_write_enable), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_req_ready", 64'(bus.req_ready), 64'd1);
      check("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("idle_select", 64'(bus.sram_select), 64'd0);
      check("idle_we", 64'(bus.sram_write_enable), 64'd0);
      @(posedge clk);
      #1;

      // Write then read the same address on the next cycle; check read latency
      do_req(mk(1'b0, 5, 32'h1234_5678, 4'hF), w);
      do_req(mk(1'b1, 5, 32'h0, 4'h0), w);
      idle();
      @(negedge clk);
      check("lat_edge1_valid", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      check("lat_edge2_valid", 64'(bus.resp_valid), 64'd1);
      check("lat_edge2_data", 64'(bus.resp_data), 64'h1234_5678);
      @(posedge clk);
      #1;
      drain();

      // 16 back-to-back reads, no back-pressure
      wsum = 0;
      for (int i = 0; i < 16; i++) begin
         do_req(mk(1'b1, i, 32'h0, 4'h0), w);
         wsum += w;
      end
      idle();
      check("b2b_ready_stalls", 64'(wsum), 64'd0);
      drain();

      // Back-pressure: only resp_depth reads accepted while resp_ready is low
      bus.resp_ready         = 1'b0;
      acc                    = 0;
      bus.req_valid          = 1'b1;
      bus.req_read_not_write = 1'b1;
      bus.req_address        = 14'(32);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            sb.push_back(gold[32 + acc]);
            acc++;
         end
         @(posedge clk);
         #1;
         bus.req_address = 14'(32 + acc);
      end
      check("bp_accepted", 64'(acc), 64'd3);
      @(negedge clk);
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
      idle();
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_at_pop", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      do_req(mk(1'b1, 35, 32'h0, 4'h0), w);
      do_req(mk(1'b1, 36, 32'h0, 4'h0), w);
      idle();
      drain();

`ifdef SRAM_SRW_MASTER_WE_EN
      // Byte-enable merge
      do_req(mk(1'b0, 9, 32'hFFFF_FFFF, 4'b1111), w);
      do_req(mk(1'b0, 9, 32'h0000_0000, 4'b0101), w);
      do_req(mk(1'b1, 9, 32'h0, 4'h0), w);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("be_merge", 64'(bus.resp_data), 64'hFF00_FF00);
      @(posedge clk);
      #1;
      drain();
`endif

      // Clock enable dropped for 4 cycles right after a read accept
      do_req(mk(1'b1, 40, 32'h0, 4'h0), w);
      en                     = 1'b0;
      bus.req_valid          = 1'b1;
      bus.req_read_not_write = 1'b1;
      bus.req_address        = 14'(41);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("dis_req_ready", 64'(bus.req_ready), 64'd0);
         check("dis_select", 64'(bus.sram_select), 64'd0);
         check("dis_resp_valid", 64'(bus.resp_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      idle();
      en = 1'b1;
      @(negedge clk);
      check("reen_valid_pre", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      check("reen_valid", 64'(bus.resp_valid), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // Reset with two buffered responses discards them
      bus.resp_ready = 1'b0;
      do_req(mk(1'b1, 50, 32'h0, 4'h0), w);
      do_req(mk(1'b1, 51, 32'h0, 4'h0), w);
      idle();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("prerst_valid", 64'(bus.resp_valid), 64'd1);
      check("prerst_data", 64'(bus.resp_data), 64'(gold[50]));
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("inrst_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("postrst_valid", 64'(bus.resp_valid), 64'd0);
      check("postrst_data", 64'(bus.resp_data), 64'd0);
      @(posedge clk);
      #1;
      rst_n          = 1'b1;
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("postrst_empty", 64'(bus.resp_valid), 64'd0);
         @(posedge clk);
         #1;
      end

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/sram_srw_access_master.md
# sram_srw_access_master

Valid/ready front end that drives one single-port `se_sram_srw*` / `se_sram_srw_we*` instance as its sole initiator. It converts a request stream (read or write) into SRAM port cycles, tracks the one-cycle SRAM read latency, and buffers read data in a small response FIFO so that responses tolerate downstream back-pressure without losing data. It sits between a bus or DMA client and any SRW SRAM macro in the design.

## Interface
- `address_width`, default 14: SRAM address bits.
- `data_width`, default 32: SRAM data bits; must be a multiple of 8 when `SRAM_SRW_MASTER_WE_EN` is defined.
- `resp_depth`, default 3: response FIFO entries (2..8); 3 gives full read throughput.
- `sram_clock` in 1: single clock; all state rises on this edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `sram_clock__enable` in 1: global clock enable; when low, no state changes.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid && req_ready`.
- `req_read_not_write` in 1: 1 = read, 0 = write.
- `req_address` in address_width: word address.
- `req_write_data` in data_width: write data.
- `req_byte_enable` in data_width/8: per-byte write mask; present only with the macro.
- `resp_valid` out 1: read data available.
- `resp_ready` in 1: consumer takes the head entry on an edge where `resp_valid && resp_ready`.
- `resp_data` out data_width: head-of-FIFO read data.
- `sram_select`, `sram_read_not_write`, `sram_address`, `sram_write_data`: out, 1/1/address_width/data_width; to the SRAM ports of the same names.
- `sram_write_enable` out: 1 bit, or data_width/8 bits with the macro.
- `sram_data_out` in data_width: SRAM read data, valid one cycle after a read select.

## Operation
- State: `count` (0..resp_depth) FIFO occupancy; `inflight` (0/1) read issued last cycle.
- `req_ready = reset_n && sram_clock__enable && (count + inflight < resp_depth)`. It does not depend on `req_valid`, the request type or `resp_ready`, so there is no combinational path from the response side.
- Accept (`fire = req_valid && req_ready`):
  - `sram_select = fire`.
  - `sram_read_not_write`, `sram_address` and `sram_write_data` are passed through combinationally from the request.
- Write accept: `sram_write_enable` is all-ones (no macro) or `req_byte_enable` (macro). It is all-zeros on a read and when idle.
- Read accept: `inflight` is set to 1 next edge, else cleared.
- When `inflight == 1`, `sram_data_out` is pushed into the FIFO on this edge.
- Pop on `resp_valid && resp_ready`.
- Push and pop on the same edge: `count` is unchanged and the data order is preserved.
- Credit rule guarantees a push never meets a full FIFO. A push while full is an assertion failure.
- Writes produce no response; read responses return in request order.
- `sram_clock__enable` low: `req_ready = 0`, `sram_select = 0`, all registers hold, and `resp_valid`/`resp_data` stay stable.
  - A read issued in the cycle before the enable drops is still captured on the first enabled edge. This relies on the SRAM sharing the same enable, which holds `data_out`.
- `reset_n` low at an edge: `count = 0`, `inflight = 0`, and all FIFO pointers are cleared. Any in-flight or buffered read is discarded.

## Timing
- Reset values:
  - `req_ready = 0` while `reset_n` is low, then 1.
  - `resp_valid = 0`.
  - `resp_data = 0`.
  - `sram_select = 0`.
  - `sram_write_enable = 0`.
- Read latency: request accepted at edge N; the SRAM samples at edge N; data is captured at edge N+1; `resp_valid` is high in cycle N+1..N+2 (first visible after edge N+1 + FIFO register). Net: `resp_valid` is asserted the cycle after edge N+1, i.e. 2 edges after acceptance.
- Throughput: one request per cycle (read or write) with `resp_ready` held high and `resp_depth >= 3`.
- Back-pressure: with `resp_ready` low, at most `resp_depth` reads are accepted, then `req_ready` drops. It rises the cycle after the pop that frees a credit.
- Write latency: the SRAM is updated at edge N. A read of the same address accepted at N+1 returns the new data.

## Configuration
- `SRAM_SRW_MASTER_WE_EN` defined:
  - `req_byte_enable` port exists.
  - `sram_write_enable` is data_width/8 bits and is driven by `req_byte_enable` on write accept.
  - Pairs with `se_sram_srw_*_we8` style macros.
- Not defined:
  - No `req_byte_enable` port.
  - `sram_write_enable` is 1 bit, set to 1 on write accept.
  - Pairs with plain write-enable macros. For macros without a write-enable port, leave the output unconnected.

## Structure
- Shared package `sram_srw_pkg`:
  - `t_sram_srw_req` struct (read_not_write, address, write_data, byte_enable).
  - Max `resp_depth` constant (8).
  - Counter width constant (4).
- Sub-module `sram_srw_resp_fifo`: synchronous FIFO of depth `resp_depth`, push/pop/count, registered head output. The top holds only the credit logic, `inflight` and the SRAM port muxing.

## Test plan
- Reset then idle → `req_ready = 1`, `resp_valid = 0`, `sram_select = 0`, `sram_write_enable = 0`.
- Write 0x12345678 to address 5, then read address 5 on the next cycle → `resp_data = 0x12345678`, `resp_valid` 2 edges after the read accept.
- 16 back-to-back reads of addresses 0..15 with `resp_ready = 1` → `req_ready` never drops; 16 responses in order.
- Hold `resp_ready = 0` and offer 5 reads → exactly 3 accepted, then `req_ready = 0`. Release → 3 responses in order; the remaining reads are then accepted.
- Macro build: write 0xFFFFFFFF, then write 0x00000000 with byte_enable 4'b0101, read back → 0xFF00FF00.
- Drop `sram_clock__enable` for 4 cycles the cycle after a read accept → no state change; the response appears correctly after re-enable. Pulse `reset_n` low with 2 entries buffered → `resp_valid = 0` and the entries are lost.
